// File: rtl/xor_checksum_acc.sv
// xor_checksum_acc
//   Folds a stream of WIDTH-bit words into a per-frame XOR checksum plus one
//   parity bit. A frame closes on an accepted beat with in_last set, or when
//   the FRAME_LEN-th word is accepted. The result is registered (1-cycle
//   latency) and held until the downstream handshake completes.
//
// Ports
//   clk, rst    : single clock domain, synchronous active-high reset
//   odd_sel     : parity mode (0 even, 1 odd), captured on the first beat
//   in_data     : input word
//   in_valid    : in_data valid
//   in_last     : final word of frame (qualified by in_valid)
//   in_ready    : block can accept a word (low in HOLD and while rst is high)
//   out_sum     : XOR of all words in the frame
//   out_parity  : reduction XOR of out_sum, XORed with the frame's odd_sel
//   out_count   : number of words in the frame
//   out_valid   : result valid
//   out_ready   : downstream accepts result
module xor_checksum_acc #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_sel,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             odd_lat;

  logic             accept;
  logic             first;
  logic             close;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_next;
  logic             odd_eff;

  function automatic logic parity_of(input logic [WIDTH-1:0] w, input logic odd);
    return (^w) ^ odd;
  endfunction

  assign in_ready = (state != HOLD) && !rst;
  assign accept   = in_valid && in_ready;
  assign first    = (state == IDLE);

  // The first beat seeds the accumulator, so no clear is needed between frames.
  assign acc_next = first ? in_data : (acc ^ in_data);
  assign cnt_next = first ? CW'(1) : (cnt + CW'(1));

  // A single-beat frame has not latched odd_sel yet, so use the live input.
  assign odd_eff  = first ? odd_sel : odd_lat;

  // in_last and the length limit on the same beat produce a single close.
  assign close    = in_last || (cnt_next == CW'(FRAME_LEN));

  // Stage boundary: accumulate on accepted beats, register result on close
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      odd_lat    <= 1'b0;
      out_sum    <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (first) odd_lat <= odd_sel;
            if (close) begin
              out_sum    <= acc_next;
              out_count  <= cnt_next;
              out_parity <= parity_of(acc_next, odd_eff);
              out_valid  <= 1'b1;
              state      <= HOLD;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/xor_checksum_acc.md
Name: xor_checksum_acc

Overview:
Parametrised, pipelined XOR accumulator for our XOR primitive family. It folds a stream of WIDTH-bit words into one word-wise XOR checksum plus a single parity bit per frame. A frame ends on in_last or after FRAME_LEN words. The block sits between a word-stream source and a downstream checker, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, data word width in bits (>=1)
FRAME_LEN, 4, maximum words per frame when in_last is not asserted (>=1)
CW, $clog2(FRAME_LEN+1), width of the word counter and out_count (derived; not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
odd_sel  input  1  parity mode: 0 = even, 1 = odd; sampled on the first accepted beat of a frame
in_data  input  WIDTH  input word
in_valid  input  1  in_data valid
in_last  input  1  marks final word of frame, qualified by in_valid
in_ready  output  1  block can accept a word
out_sum  output  WIDTH  XOR of all words in frame
out_parity  output  1  reduction XOR of out_sum, XOR the latched odd_sel
out_count  output  CW  number of words in frame
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result

Behaviour:
- Only one clock domain: clk. Reset is synchronous and active-high.
- States are IDLE (no frame open), ACCUM (frame open) and HOLD (result presented).
- Reset (rst high at a clock edge):
  - state -> IDLE; accumulator, counter, out_sum, out_parity, out_count, out_valid -> 0.
  - in_ready is forced 0 while rst is high and is 1 in the first cycle after rst falls.
  - A partial frame is discarded with no output.
- in_ready is combinational: 1 when state != HOLD and rst = 0.
- Beat acceptance requires in_valid & in_ready at the clock edge. In HOLD, in_valid is ignored and the word stays pending at the source.
- First beat of a frame (state IDLE):
  - acc <= in_data, cnt <= 1, odd_sel is latched, state -> ACCUM.
- Later beats:
  - acc <= acc ^ in_data, cnt <= cnt + 1.
- Frame close: the accepted beat has in_last = 1, OR cnt + 1 == FRAME_LEN. At that edge:
  - out_sum <= acc_next, out_count <= cnt_next.
  - out_parity <= (^acc_next) ^ odd_sel_latched. For a single-beat frame, use the live odd_sel.
  - out_valid <= 1, state -> HOLD.
  - Latency is 1 cycle: out_valid is high in the cycle after the closing beat.
- Single-beat frames: FRAME_LEN = 1, or in_last on the first beat, closes the frame from IDLE directly to HOLD.
- If in_last and the FRAME_LEN limit hit on the same beat, there is one close and no extra empty frame.
- Counter never wraps, since cnt <= FRAME_LEN always.
- HOLD:
  - out_sum, out_parity and out_count are stable while out_valid = 1 and out_ready = 0.
  - On out_valid & out_ready: out_valid <= 0, state -> IDLE.
  - out_sum, out_parity and out_count hold their last values after out_valid drops.
- Next-frame timing: in_ready rises the cycle after the output handshake, giving one bubble cycle between frames. There is no same-cycle bypass.
- Gaps: in_valid gaps inside a frame do not change the result.
- odd_sel changes mid-frame have no effect on the open frame.

Test Plan:
1. Reset (WIDTH=8, FRAME_LEN=4): hold rst high for 2 cycles with in_valid=1 -> in_ready=0 throughout, out_valid=0, out_sum=0x00, out_count=0; after rst falls, in_ready=1 on the next cycle.
2. Full frame, odd_sel=0: send 0x01, 0x02, 0x04, 0x08 back-to-back with in_last=0 and out_ready=1 -> the cycle after the 4th beat, out_valid=1, out_sum=0x0F, out_parity=0, out_count=4; the next cycle out_valid=0 and in_ready=1.
3. Early last, odd_sel=1: send 0xFF then 0x0F with in_last=1 on the 2nd beat -> out_sum=0xF0, out_parity=1, out_count=2.
4. Backpressure: after a frame 0x3C (in_last=1), hold out_ready=0 for 5 cycles while the source holds in_valid=1, in_data=0xAA -> out_sum stays 0x3C, in_ready=0, 0xAA not accepted. Raise out_ready -> handshake, then 0xAA is accepted as the first word of the next frame; closing with in_last=1 gives out_sum=0xAA, out_count=1.
5. Reset mid-frame: accept 0x11 and 0x22, pulse rst for 1 cycle, then send 0x33 with in_last=1 -> out_sum=0x33, out_count=1, out_parity=0 (odd_sel=0); no output for the aborted frame.
6. Gapped input: the same words as scenario 2 with 3 idle cycles between beats, and odd_sel toggled during the gaps -> identical result: 0x0F, parity 0, count 4.
